// File: rtl/tone_synth_kbd.sv
// PS/2-keyboard-driven square-wave tone synthesiser with a runtime octave, PWM volume and mute.
// It sounds the last-pressed note until that key is released.
module tone_synth_kbd #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int CNT_W   = 24,
  parameter int OCT_MIN = 2,
  parameter int OCT_MAX = 6,
  parameter int OCT_RST = 4,
  parameter int VOL_W   = 3,
  parameter int PWM_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       scan_code,
  input  logic             scan_valid,
  output logic             pwm_out,
  output logic             note_active,
  output logic [2:0]       cur_note,
  output logic [2:0]       octave,
  output logic [VOL_W-1:0] volume,
  output logic             muted,
  output logic [CNT_W-1:0] half_period
);

  localparam logic [2:0]       OCT_MIN_V = 3'(OCT_MIN);
  localparam logic [2:0]       OCT_MAX_V = 3'(OCT_MAX);
  localparam logic [2:0]       OCT_RST_V = 3'(OCT_RST);
  localparam logic [VOL_W-1:0] VOL_RST   = {1'b1, {(VOL_W-1){1'b0}}};
  localparam logic [VOL_W-1:0] VOL_MAX   = '1;

  // Half-periods of the lowest octave, rounded to the nearest clock.
  localparam logic [CNT_W-1:0] BASE_C = CNT_W'($rtoi(CLK_HZ / (2.0 * 65.406) + 0.5));
  localparam logic [CNT_W-1:0] BASE_D = CNT_W'($rtoi(CLK_HZ / (2.0 * 73.416) + 0.5));
  localparam logic [CNT_W-1:0] BASE_E = CNT_W'($rtoi(CLK_HZ / (2.0 * 82.407) + 0.5));
  localparam logic [CNT_W-1:0] BASE_F = CNT_W'($rtoi(CLK_HZ / (2.0 * 87.307) + 0.5));
  localparam logic [CNT_W-1:0] BASE_G = CNT_W'($rtoi(CLK_HZ / (2.0 * 97.999) + 0.5));
  localparam logic [CNT_W-1:0] BASE_A = CNT_W'($rtoi(CLK_HZ / (2.0 * 110.000) + 0.5));
  localparam logic [CNT_W-1:0] BASE_B = CNT_W'($rtoi(CLK_HZ / (2.0 * 123.471) + 0.5));

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} dec_state_t;

  dec_state_t       state, state_next;
  logic             make_evt, brk_evt;
  logic             is_note;
  logic [2:0]       key_note;
  logic             tab_held;
  logic             phase;
  logic [CNT_W-1:0] tone_cnt;
  logic [CNT_W-1:0] hp_reg;
  logic [PWM_W-1:0] carrier;
  logic             gate;

  function automatic logic [CNT_W-1:0] period_of(input logic [2:0] n, input logic [2:0] o);
    logic [CNT_W-1:0] b;
    case (n)
      3'd0:    b = BASE_C;
      3'd1:    b = BASE_D;
      3'd2:    b = BASE_E;
      3'd3:    b = BASE_F;
      3'd4:    b = BASE_G;
      3'd5:    b = BASE_A;
      default: b = BASE_B;
    endcase
    return b >> (o - OCT_MIN_V);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    make_evt   = 1'b0;
    brk_evt    = 1'b0;
    if (scan_valid) begin
      case (state)
        IDLE: begin
          if (scan_code == 8'hF0)      state_next = BRK;
          else if (scan_code == 8'hE0) state_next = EXT;
          else                         make_evt   = 1'b1;
        end
        BRK: begin
          brk_evt    = 1'b1;
          state_next = IDLE;
        end
        EXT:     state_next = (scan_code == 8'hF0) ? EXTBRK : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    is_note  = 1'b1;
    key_note = 3'd0;
    case (scan_code)
      8'h23:   key_note = 3'd0;
      8'h2D:   key_note = 3'd1;
      8'h3A:   key_note = 3'd2;
      8'h2B:   key_note = 3'd3;
      8'h1B:   key_note = 3'd4;
      8'h4B:   key_note = 3'd5;
      8'h21:   key_note = 3'd6;
      default: is_note  = 1'b0;
    endcase
  end

  // The active half-period is reloaded only on a restart or a wrap, so octave changes land on a boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_active <= 1'b0;
      cur_note    <= 3'd0;
      tone_cnt    <= '0;
      phase       <= 1'b0;
      hp_reg      <= '0;
    end else if (make_evt && is_note) begin
      note_active <= 1'b1;
      cur_note    <= key_note;
      tone_cnt    <= '0;
      phase       <= 1'b0;
      hp_reg      <= period_of(key_note, octave);
    end else if (brk_evt && is_note && note_active && key_note == cur_note) begin
      note_active <= 1'b0;
      cur_note    <= 3'd0;
      tone_cnt    <= '0;
      phase       <= 1'b0;
      hp_reg      <= '0;
    end else if (note_active) begin
      if (tone_cnt == hp_reg - CNT_W'(1)) begin
        tone_cnt <= '0;
        phase    <= ~phase;
        hp_reg   <= period_of(cur_note, octave);
      end else begin
        tone_cnt <= tone_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      octave   <= OCT_RST_V;
      volume   <= VOL_RST;
      muted    <= 1'b0;
      tab_held <= 1'b0;
    end else begin
      if (make_evt) begin
        case (scan_code)
          8'h55: if (octave < OCT_MAX_V) octave <= octave + 3'd1;
          8'h4E: if (octave > OCT_MIN_V) octave <= octave - 3'd1;
          8'h5B: if (volume != VOL_MAX) volume <= volume + VOL_W'(1);
          8'h54: if (volume != '0) volume <= volume - VOL_W'(1);
          8'h0D: begin
            if (!tab_held) muted <= ~muted;
            tab_held <= 1'b1;
          end
          default: ;
        endcase
      end
      if (brk_evt && scan_code == 8'h0D) tab_held <= 1'b0;
    end
  end

  assign gate        = carrier < {volume, {(PWM_W-VOL_W){1'b0}}};
  assign half_period = hp_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carrier <= '0;
      pwm_out <= 1'b0;
    end else begin
      carrier <= carrier + PWM_W'(1);
      pwm_out <= note_active & ~muted & phase & gate;
    end
  end

endmodule
